// File: rtl/bot_permute_burst_scheduler.sv
// Burst sequencer in front of botPermuter: a 2-entry bot buffer, credit gate
// and reset holdoff so every burst issued has room downstream.
module bot_permute_burst_scheduler #(
  parameter int EXTRA_DATA_WIDTH = 12,
  parameter int MAX_CREDITS      = 32,
  parameter int CREDIT_WIDTH     = 6,
  parameter int RST_HOLDOFF      = 3
) (
  input  logic                        clk,
  input  logic                        rstN,
  input  logic [127:0]                botIn,
  input  logic [5:0]                  validBotPermutesIn,
  input  logic [EXTRA_DATA_WIDTH-1:0] extraDataIn,
  input  logic                        inValid,
  output logic                        inReady,
  output logic                        permStartNewBurst,
  output logic [127:0]                permBot,
  output logic [5:0]                  permValidMask,
  output logic [EXTRA_DATA_WIDTH-1:0] permExtraData,
  output logic                        permRst,
  input  logic                        permDone,
  input  logic                        creditReturn,
  output logic [CREDIT_WIDTH-1:0]     creditsAvailable,
  output logic [31:0]                 burstsIssued,
  output logic [15:0]                 zeroMaskDropped,
  output logic                        idle
);

  typedef enum logic [1:0] {
    HOLDOFF,
    READY,
    WAIT1,
    WAIT2
  } state_t;

  localparam int HW = $clog2(RST_HOLDOFF + 1);
  localparam logic [HW-1:0] HLAST = HW'(RST_HOLDOFF - 1);
  localparam logic [CREDIT_WIDTH-1:0] CMAX = CREDIT_WIDTH'(MAX_CREDITS);

  state_t state, state_nxt;
  logic [HW-1:0] hold_cnt;
  logic rst_q;

  logic [127:0]                bot_q   [2];
  logic [5:0]                  mask_q  [2];
  logic [EXTRA_DATA_WIDTH-1:0] extra_q [2];
  logic       rd_ptr, wr_ptr;
  logic [1:0] cnt, cnt_nxt;

  logic [CREDIT_WIDTH-1:0] credits, credits_nxt;
  logic [2:0] need;
  logic       have_head, head_zero;
  logic       issue, drop, pop, push, ret_ok;

  assign permBot       = bot_q[rd_ptr];
  assign permValidMask = mask_q[rd_ptr];
  assign permExtraData = extra_q[rd_ptr];

  always_comb begin
    need = '0;
    for (int i = 0; i < 6; i++) begin
      need = need + {2'b00, permValidMask[i]};
    end
  end

  assign have_head = cnt != 2'd0;
  assign head_zero = permValidMask == 6'd0;
  assign issue = (state == READY) && have_head && !head_zero
              && permDone && (credits >= CREDIT_WIDTH'(need));
  // Zero-mask beats are discarded in any state so they never cost a slot.
  assign drop = have_head && head_zero;
  assign pop  = issue || drop;
  assign push = inValid && inReady;
  assign cnt_nxt = 2'(cnt + {1'b0, push} - {1'b0, pop});

  // Returns beyond the pool size would be a downstream bug; never overflow.
  assign ret_ok = creditReturn && (credits != CMAX);
  assign credits_nxt = credits
                     - (issue ? CREDIT_WIDTH'(need) : '0)
                     + CREDIT_WIDTH'(ret_ok);

  always_comb begin
    state_nxt = state;
    unique case (state)
      HOLDOFF: if (hold_cnt == HLAST) state_nxt = READY;
      READY:   if (issue) state_nxt = WAIT1;
      WAIT1:   state_nxt = WAIT2;
      WAIT2:   state_nxt = READY;
      default: state_nxt = HOLDOFF;
    endcase
  end

  assign permStartNewBurst = issue;
  assign permRst = !rstN || rst_q;
  assign creditsAvailable = credits;
  assign idle = !have_head && (state == READY) && (credits == CMAX);

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state           <= HOLDOFF;
      hold_cnt        <= '0;
      rst_q           <= 1'b1;
      inReady         <= 1'b0;
      rd_ptr          <= 1'b0;
      wr_ptr          <= 1'b0;
      cnt             <= 2'd0;
      credits         <= CMAX;
      burstsIssued    <= '0;
      zeroMaskDropped <= '0;
      for (int i = 0; i < 2; i++) begin
        bot_q[i]   <= '0;
        mask_q[i]  <= '0;
        extra_q[i] <= '0;
      end
    end else begin
      state   <= state_nxt;
      rst_q   <= 1'b0;
      cnt     <= cnt_nxt;
      credits <= credits_nxt;
      inReady <= (cnt_nxt != 2'd2) && (state_nxt != HOLDOFF);
      if (state == HOLDOFF) hold_cnt <= hold_cnt + HW'(1);
      if (push) begin
        bot_q[wr_ptr]   <= botIn;
        mask_q[wr_ptr]  <= validBotPermutesIn;
        extra_q[wr_ptr] <= extraDataIn;
        wr_ptr          <= !wr_ptr;
      end
      if (pop) rd_ptr <= !rd_ptr;
      if (issue) burstsIssued <= burstsIssued + 32'd1;
      if (drop && zeroMaskDropped != 16'hFFFF) begin
        zeroMaskDropped <= zeroMaskDropped + 16'd1;
      end
    end
  end

  credit_no_overflow: assert property (
    @(posedge clk) disable iff (!rstN)
    !(creditReturn && credits == CMAX)
  ) else $error("credit returned with pool already full");

endmodule

// File: tb/tb_bot_permute_burst_scheduler.sv
// Directed bench: default instance (32 credits) and a 6-credit instance
// share clock and reset; each step drives at negedge and checks 1ns later.
module tb_bot_permute_burst_scheduler;

  logic clk = 1'b0;
  logic rstN = 1'b0;
  always #5 clk = ~clk;

  logic [127:0] a_bot, a_pbot, b_bot, b_pbot;
  logic [5:0]   a_mask, a_pmask, b_mask, b_pmask;
  logic [11:0]  a_extra, a_pextra, b_extra, b_pextra;
  logic a_valid, a_ready, a_start, a_prst, a_done, a_ret, a_idle;
  logic b_valid, b_ready, b_start, b_prst, b_done, b_ret, b_idle;
  logic [5:0]  a_cred, b_cred;
  logic [31:0] a_bursts, b_bursts;
  logic [15:0] a_zero, b_zero;

  int errors = 0;
  int checks = 0;

  bot_permute_burst_scheduler u_a (
    .clk(clk), .rstN(rstN),
    .botIn(a_bot), .validBotPermutesIn(a_mask),
    .extraDataIn(a_extra), .inValid(a_valid),
    .inReady(a_ready), .permStartNewBurst(a_start),
    .permBot(a_pbot), .permValidMask(a_pmask),
    .permExtraData(a_pextra), .permRst(a_prst),
    .permDone(a_done), .creditReturn(a_ret),
    .creditsAvailable(a_cred), .burstsIssued(a_bursts),
    .zeroMaskDropped(a_zero), .idle(a_idle)
  );

  bot_permute_burst_scheduler #(.MAX_CREDITS(6)) u_b (
    .clk(clk), .rstN(rstN),
    .botIn(b_bot), .validBotPermutesIn(b_mask),
    .extraDataIn(b_extra), .inValid(b_valid),
    .inReady(b_ready), .permStartNewBurst(b_start),
    .permBot(b_pbot), .permValidMask(b_pmask),
    .permExtraData(b_pextra), .permRst(b_prst),
    .permDone(b_done), .creditReturn(b_ret),
    .creditsAvailable(b_cred), .burstsIssued(b_bursts),
    .zeroMaskDropped(b_zero), .idle(b_idle)
  );

  task automatic chk(input string tag, input logic [127:0] obs,
                     input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic ret_a(input int n);
    @(negedge clk);
    a_ret = 1'b1;
    repeat (n) @(negedge clk);
    a_ret = 1'b0;
    #1;
  endtask

  task automatic ret_b(input int n);
    @(negedge clk);
    b_ret = 1'b1;
    repeat (n) @(negedge clk);
    b_ret = 1'b0;
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    a_bot = '0; a_mask = '0; a_extra = '0;
    a_valid = 0; a_done = 0; a_ret = 0;
    b_bot = '0; b_mask = '0; b_extra = '0;
    b_valid = 0; b_done = 0; b_ret = 0;

    // reset values
    repeat (2) @(negedge clk);
    #1;
    chk("rst_ready", a_ready, 0);
    chk("rst_start", a_start, 0);
    chk("rst_cred", a_cred, 32);
    chk("rst_bursts", a_bursts, 0);
    chk("rst_zero", a_zero, 0);
    chk("rst_prst", a_prst, 1);
    chk("rst_idle", a_idle, 0);
    chk("rst_b_cred", b_cred, 6);
    chk("rst_b_zero", b_zero, 0);
    chk("rst_b_prst", b_prst, 1);

    // single full-mask beat offered from the release cycle
    @(negedge clk);
    rstN = 1; a_valid = 1; a_done = 1;
    a_bot = {4{32'h1111_2222}}; a_mask = 6'h3F; a_extra = 12'hABC;
    #1;
    chk("c0_prst", a_prst, 1);
    chk("c0_ready", a_ready, 0);
    chk("c0_start", a_start, 0);
    @(negedge clk); #1;
    chk("c1_prst", a_prst, 0);
    chk("c1_start", a_start, 0);
    @(negedge clk); #1;
    chk("c2_ready", a_ready, 0);
    chk("c2_start", a_start, 0);
    @(negedge clk); #1;
    chk("c3_ready", a_ready, 1);
    chk("c3_start", a_start, 0);
    @(negedge clk);
    a_valid = 0;
    #1;
    chk("t1_start", a_start, 1);
    chk("t1_bot", a_pbot, {4{32'h1111_2222}});
    chk("t1_mask", a_pmask, 6'h3F);
    chk("t1_extra", a_pextra, 12'hABC);
    chk("t1_cred_pre", a_cred, 32);
    @(negedge clk); #1;
    chk("t1_cred", a_cred, 26);
    chk("t1_bursts", a_bursts, 1);
    chk("t1_start_off", a_start, 0);
    ret_a(6);
    chk("t1_cred_back", a_cred, 32);
    chk("t1_idle", a_idle, 1);

    // zero-mask beat between two real ones
    @(negedge clk);
    a_valid = 1; a_mask = 6'b000011; a_bot = 128'hA1; a_extra = 12'h001;
    #1;
    chk("t2_ready0", a_ready, 1);
    @(negedge clk);
    a_mask = 6'b000000; a_bot = 128'hA2; a_extra = 12'h002;
    #1;
    chk("t2_issue1", a_start, 1);
    chk("t2_mask1", a_pmask, 6'b000011);
    chk("t2_ready1", a_ready, 1);
    @(negedge clk);
    a_mask = 6'b100000; a_bot = 128'hA3; a_extra = 12'h003;
    #1;
    chk("t2_w1_start", a_start, 0);
    chk("t2_ready2", a_ready, 1);
    chk("t2_cred30", a_cred, 30);
    @(negedge clk);
    a_valid = 0;
    #1;
    chk("t2_w2_start", a_start, 0);
    chk("t2_dropped", a_zero, 1);
    @(negedge clk); #1;
    chk("t2_issue2", a_start, 1);
    chk("t2_mask2", a_pmask, 6'b100000);
    chk("t2_extra2", a_pextra, 12'h003);
    @(negedge clk); #1;
    chk("t2_cred", a_cred, 29);
    chk("t2_bursts", a_bursts, 3);
    chk("t2_start_off", a_start, 0);
    ret_a(3);
    chk("t2_cred_back", a_cred, 32);

    // full buffer with permuter busy
    @(negedge clk);
    a_done = 0; a_valid = 1;
    a_bot = 128'hD1; a_mask = 6'b000111; a_extra = 12'h111;
    #1;
    chk("t5_ready_d1", a_ready, 1);
    @(negedge clk);
    a_bot = 128'hD2; a_mask = 6'b010101; a_extra = 12'h222;
    #1;
    chk("t5_ready_d2", a_ready, 1);
    @(negedge clk);
    a_bot = 128'hD3; a_mask = 6'b101010; a_extra = 12'h333;
    #1;
    chk("t5_full", a_ready, 0);
    for (int i = 0; i < 19; i++) begin
      @(negedge clk); #1;
      chk("t5_hold_ready", a_ready, 0);
      chk("t5_hold_start", a_start, 0);
    end
    @(negedge clk);
    a_done = 1;
    #1;
    chk("t5_iss_d1", a_start, 1);
    chk("t5_bot_d1", a_pbot, 128'hD1);
    chk("t5_ext_d1", a_pextra, 12'h111);
    chk("t5_pop_ready", a_ready, 0);
    @(negedge clk); #1;
    chk("t5_ready_rise", a_ready, 1);
    chk("t5_w1", a_start, 0);
    @(negedge clk);
    a_valid = 0;
    #1;
    chk("t5_w2", a_start, 0);
    @(negedge clk); #1;
    chk("t5_iss_d2", a_start, 1);
    chk("t5_bot_d2", a_pbot, 128'hD2);
    chk("t5_ext_d2", a_pextra, 12'h222);
    @(negedge clk); #1;
    chk("t5_w1b", a_start, 0);
    @(negedge clk); #1;
    chk("t5_w2b", a_start, 0);
    @(negedge clk); #1;
    chk("t5_iss_d3", a_start, 1);
    chk("t5_bot_d3", a_pbot, 128'hD3);
    chk("t5_ext_d3", a_pextra, 12'h333);

    // reset during WAIT1
    @(negedge clk);
    a_valid = 1; a_bot = 128'hE1; a_mask = 6'b000001; a_extra = 12'h0EE;
    #1;
    chk("t5_cred", a_cred, 23);
    chk("t5_bursts", a_bursts, 6);
    chk("t6_ready", a_ready, 1);
    @(negedge clk);
    a_valid = 0;
    #1;
    chk("t6_w2", a_start, 0);
    @(negedge clk); #1;
    chk("t6_issue", a_start, 1);
    chk("t6_extra", a_pextra, 12'h0EE);
    @(negedge clk);
    rstN = 0;
    #1;
    chk("t6_prst", a_prst, 1);
    chk("t6_ready", a_ready, 0);
    chk("t6_start", a_start, 0);
    chk("t6_cred", a_cred, 32);
    chk("t6_bursts", a_bursts, 0);
    chk("t6_zero", a_zero, 0);
    chk("t6_idle0", a_idle, 0);
    @(negedge clk);
    rstN = 1;
    #1;
    chk("t6_c0_prst", a_prst, 1);
    @(negedge clk); #1;
    @(negedge clk); #1;
    chk("t6_c2_idle", a_idle, 0);
    @(negedge clk); #1;
    chk("t6_c3_idle", a_idle, 1);
    chk("t6_c3_ready", a_ready, 1);
    chk("b_cred_init", b_cred, 6);
    chk("b_idle_init", b_idle, 1);

    // 6-credit pool: second full burst waits for returns
    @(negedge clk);
    b_done = 1; b_valid = 1;
    b_bot = 128'hF1; b_mask = 6'h3F; b_extra = 12'h0F1;
    #1;
    chk("t3_ready", b_ready, 1);
    @(negedge clk);
    b_bot = 128'hF2; b_extra = 12'h0F2;
    #1;
    chk("t3_iss1", b_start, 1);
    chk("t3_bot1", b_pbot, 128'hF1);
    @(negedge clk);
    b_valid = 0;
    #1;
    chk("t3_cred0", b_cred, 0);
    chk("t3_w1", b_start, 0);
    @(negedge clk); #1;
    chk("t3_w2", b_start, 0);
    @(negedge clk);
    b_ret = 1;
    #1;
    chk("t3_stall0", b_start, 0);
    for (int i = 1; i < 6; i++) begin
      @(negedge clk); #1;
      chk("t3_stall", b_start, 0);
      chk("t3_cred_up", b_cred, i);
    end
    @(negedge clk);
    b_ret = 0;
    #1;
    chk("t3_cred6", b_cred, 6);
    chk("t3_iss2", b_start, 1);
    chk("t3_bot2", b_pbot, 128'hF2);
    chk("t3_ext2", b_pextra, 12'h0F2);
    @(negedge clk); #1;
    chk("t3_cred_end", b_cred, 0);
    chk("t3_bursts", b_bursts, 2);
    ret_b(6);
    chk("t3_refill", b_cred, 6);

    // issue need=2 at credits=2 with a same-cycle return
    @(negedge clk);
    b_valid = 1; b_bot = 128'hC1; b_mask = 6'b001111;
    #1;
    chk("t4_ready", b_ready, 1);
    @(negedge clk);
    b_bot = 128'hC2; b_mask = 6'b000011;
    #1;
    chk("t4_iss1", b_start, 1);
    chk("t4_mask1", b_pmask, 6'b001111);
    @(negedge clk);
    b_valid = 0;
    #1;
    chk("t4_cred2", b_cred, 2);
    @(negedge clk); #1;
    chk("t4_w2", b_start, 0);
    @(negedge clk);
    b_ret = 1;
    #1;
    chk("t4_iss2", b_start, 1);
    chk("t4_mask2", b_pmask, 6'b000011);
    @(negedge clk);
    b_ret = 0;
    #1;
    chk("t4_cred1", b_cred, 1);
    chk("t4_bursts", b_bursts, 4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
